// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one memory port between two requesters.
// Supports wrapping burst reads, a per-beat timeout and fully registered outputs.
module mem_port_arbiter #(
    parameter int ADDRESS_LENGTH = 19,
    parameter int DATA_WIDTH     = 8,
    parameter int BURST_LEN      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      Req0_Read,
    input  logic                      Req0_Write,
    input  logic                      Req0_Burst,
    input  logic [ADDRESS_LENGTH-1:0] Req0_Address,
    input  logic [DATA_WIDTH-1:0]     Req0_WData,
    input  logic                      Req1_Read,
    input  logic                      Req1_Write,
    input  logic                      Req1_Burst,
    input  logic [ADDRESS_LENGTH-1:0] Req1_Address,
    input  logic [DATA_WIDTH-1:0]     Req1_WData,
    output logic                      Grant0,
    output logic                      Grant1,
    output logic                      Req0_Read_Ready,
    output logic                      Req0_Write_Ready,
    output logic                      Req1_Read_Ready,
    output logic                      Req1_Write_Ready,
    output logic [DATA_WIDTH-1:0]     Rd_Data,
    output logic                      Mem_Read,
    output logic                      Mem_Write,
    output logic [ADDRESS_LENGTH-1:0] Mem_Address,
    output logic [DATA_WIDTH-1:0]     Mem_WData,
    input  logic                      Mem_Read_Ready,
    input  logic                      Mem_Write_Ready,
    input  logic [DATA_WIDTH-1:0]     Mem_RData,
    output logic                      Timeout_Error
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;
    state_t                    state, state_n;
    logic                      owner, owner_n, is_read, is_read_n, burst, burst_n;
    logic                      last_grant, last_grant_n;
    logic [1:0]                beat, beat_n, grant, grant_n;
    logic [3:0]                rdy, rdy_n;
    logic [TW-1:0]             tcnt, tcnt_n;
    logic [ADDRESS_LENGTH-1:0] base, base_n, mem_address_n;
    logic [DATA_WIDTH-1:0]     mem_wdata_n, rd_data_n;
    logic                      mem_read_n, mem_write_n, tmo, tmo_n;
    logic                      r0, r1, sel1, sel_read, hit;
    assign r0       = Req0_Read | Req0_Write;
    assign r1       = Req1_Read | Req1_Write;
    // On conflict the requester that was not granted last goes first
    assign sel1     = r1 & (~r0 | ~last_grant);
    assign sel_read = sel1 ? Req1_Read : Req0_Read;
    assign hit      = is_read ? Mem_Read_Ready : Mem_Write_Ready;
    always_comb begin
        state_n       = state;
        owner_n       = owner;
        is_read_n     = is_read;
        burst_n       = burst;
        last_grant_n  = last_grant;
        beat_n        = beat;
        grant_n       = grant;
        tcnt_n        = tcnt;
        base_n        = base;
        mem_address_n = Mem_Address;
        mem_wdata_n   = Mem_WData;
        rd_data_n     = Rd_Data;
        mem_read_n    = 1'b0;
        mem_write_n   = 1'b0;
        rdy_n         = '0;
        tmo_n         = 1'b0;
        case (state)
            IDLE: if (r0 | r1) begin
                owner_n       = sel1;
                is_read_n     = sel_read;
                burst_n       = sel_read & (sel1 ? Req1_Burst : Req0_Burst);
                base_n        = sel1 ? Req1_Address : Req0_Address;
                mem_address_n = sel1 ? Req1_Address : Req0_Address;
                mem_wdata_n   = sel1 ? Req1_WData : Req0_WData;
                grant_n       = sel1 ? 2'b10 : 2'b01;
                mem_read_n    = sel_read;
                mem_write_n   = ~sel_read;
                beat_n        = 2'd0;
                state_n       = ISSUE;
            end
            ISSUE: begin
                tcnt_n  = '0;
                state_n = WAIT;
            end
            WAIT: if (hit) begin
                rdy_n[{owner, ~is_read}] = 1'b1;
                rd_data_n = is_read ? Mem_RData : Rd_Data;
                // Remaining burst beats wrap within the aligned 4-word line
                if (burst && beat != 2'(BURST_LEN - 1)) begin
                    beat_n        = beat + 2'd1;
                    mem_read_n    = 1'b1;
                    mem_address_n = {base[ADDRESS_LENGTH-1:2], base[1:0] + beat + 2'd1};
                    state_n       = ISSUE;
                end else begin
                    state_n = RELEASE;
                end
            end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                rdy_n[{owner, ~is_read}] = 1'b1;
                rd_data_n = '0;
                tmo_n     = 1'b1;
                state_n   = RELEASE;
            end else begin
                tcnt_n = (tcnt == TW'(TIMEOUT_CYCLES)) ? tcnt : tcnt + TW'(1);
            end
            RELEASE: begin
                grant_n      = 2'b00;
                last_grant_n = owner;
                state_n      = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            owner       <= 1'b0;
            is_read     <= 1'b0;
            burst       <= 1'b0;
            last_grant  <= 1'b1;
            beat        <= 2'd0;
            grant       <= 2'b00;
            tcnt        <= '0;
            base        <= '0;
            Mem_Address <= '0;
            Mem_WData   <= '0;
            Rd_Data     <= '0;
            Mem_Read    <= 1'b0;
            Mem_Write   <= 1'b0;
            rdy         <= '0;
            tmo         <= 1'b0;
        end else begin
            state       <= state_n;
            owner       <= owner_n;
            is_read     <= is_read_n;
            burst       <= burst_n;
            last_grant  <= last_grant_n;
            beat        <= beat_n;
            grant       <= grant_n;
            tcnt        <= tcnt_n;
            base        <= base_n;
            Mem_Address <= mem_address_n;
            Mem_WData   <= mem_wdata_n;
            Rd_Data     <= rd_data_n;
            Mem_Read    <= mem_read_n;
            Mem_Write   <= mem_write_n;
            rdy         <= rdy_n;
            tmo         <= tmo_n;
        end
    end
    assign Grant0           = grant[0];
    assign Grant1           = grant[1];
    assign Req0_Read_Ready  = rdy[0];
    assign Req0_Write_Ready = rdy[1];
    assign Req1_Read_Ready  = rdy[2];
    assign Req1_Write_Ready = rdy[3];
    assign Timeout_Error    = tmo;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random transactions against a transaction-level model
// of arbitration order, burst address wrap, beat timing and timeouts.
module tb_mem_port_arbiter;
    logic        Clk = 1'b0, Reset_n = 1'b0;
    logic        Req0_Read = 0, Req0_Write = 0, Req0_Burst = 0, Req1_Read = 0, Req1_Write = 0, Req1_Burst = 0;
    logic [18:0] Req0_Address = 0, Req1_Address = 0, Mem_Address;
    logic [7:0]  Req0_WData = 0, Req1_WData = 0, Rd_Data, Mem_WData, Mem_RData = 0;
    logic        Grant0, Grant1, Req0_Read_Ready, Req0_Write_Ready, Req1_Read_Ready, Req1_Write_Ready;
    logic        Mem_Read, Mem_Write, Mem_Read_Ready = 0, Mem_Write_Ready = 0, Timeout_Error;
    typedef struct { int cyc; logic rd; logic [18:0] addr; logic [7:0] wd; } strobe_t;
    typedef struct { int cyc; int who; logic [7:0] data; logic tmo; } rdy_t;
    strobe_t sq[$];
    rdy_t    rq[$];
    int      checks = 0, errors = 0, cyc = 0, lat = 1, last = 1;
    logic    prev_strobe = 0;
    logic [3:0] rv;
    assign rv = {Req1_Write_Ready, Req1_Read_Ready, Req0_Write_Ready, Req0_Read_Ready};
    mem_port_arbiter #(.ADDRESS_LENGTH(19), .DATA_WIDTH(8), .BURST_LEN(4), .TIMEOUT_CYCLES(8)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .Req0_Read(Req0_Read), .Req0_Write(Req0_Write), .Req0_Burst(Req0_Burst),
        .Req0_Address(Req0_Address), .Req0_WData(Req0_WData),
        .Req1_Read(Req1_Read), .Req1_Write(Req1_Write), .Req1_Burst(Req1_Burst),
        .Req1_Address(Req1_Address), .Req1_WData(Req1_WData),
        .Grant0(Grant0), .Grant1(Grant1),
        .Req0_Read_Ready(Req0_Read_Ready), .Req0_Write_Ready(Req0_Write_Ready),
        .Req1_Read_Ready(Req1_Read_Ready), .Req1_Write_Ready(Req1_Write_Ready),
        .Rd_Data(Rd_Data), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
        .Mem_Address(Mem_Address), .Mem_WData(Mem_WData),
        .Mem_Read_Ready(Mem_Read_Ready), .Mem_Write_Ready(Mem_Write_Ready),
        .Mem_RData(Mem_RData), .Timeout_Error(Timeout_Error)
    );
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic logic [7:0] mem_f(input logic [18:0] a);
        return a[7:0] ^ 8'hA0;
    endfunction
    function automatic logic [2:0] op_of(input int k);
        case (k)
            1: return 3'b001;
            2: return 3'b010;
            3: return 3'b101;
            4: return 3'b011;
            5: return 3'b110;
            default: return 3'b000;
        endcase
    endfunction
    // Memory: answers each strobe 'lat' cycles later (lat 0 = never answers)
    initial begin
        logic        pend = 0, prd = 0;
        logic [18:0] paddr = 0;
        int          cnt = 0;
        forever begin
            @(negedge Clk);
            Mem_Read_Ready = 0;
            Mem_Write_Ready = 0;
            Mem_RData = 8'($urandom);
            if (Mem_Read | Mem_Write) begin
                pend = (lat != 0); prd = Mem_Read; paddr = Mem_Address; cnt = lat;
            end else if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    pend = 0;
                    if (prd) begin Mem_Read_Ready = 1; Mem_RData = mem_f(paddr); end
                    else Mem_Write_Ready = 1;
                end
            end
        end
    end
    always @(negedge Clk) begin
        chk("grant_excl", 64'(Grant0 & Grant1), 0);
        chk("strobe_excl", 64'(Mem_Read & Mem_Write), 0);
        chk("strobe_width", 64'(prev_strobe & (Mem_Read | Mem_Write)), 0);
        chk("ready_onehot", 64'($countones(rv) > 1), 0);
        chk("ready0_grant", 64'(|rv[1:0] & ~Grant0), 0);
        chk("ready1_grant", 64'(|rv[3:2] & ~Grant1), 0);
        chk("tmo_with_ready", 64'(Timeout_Error & ~|rv), 0);
        prev_strobe <= Mem_Read | Mem_Write;
        if (Mem_Read | Mem_Write) sq.push_back('{cyc, Mem_Read, Mem_Address, Mem_WData});
        for (int i = 0; i < 4; i++) if (rv[i]) rq.push_back('{cyc, i, Rd_Data, Timeout_Error});
    end
    task automatic drive(input int who, input logic [2:0] op, input logic [18:0] a, input logic [7:0] d);
        if (who == 0) begin
            Req0_Read = op[0]; Req0_Write = op[1]; Req0_Burst = op[2]; Req0_Address = a; Req0_WData = d;
        end else begin
            Req1_Read = op[0]; Req1_Write = op[1]; Req1_Burst = op[2]; Req1_Address = a; Req1_WData = d;
        end
    endtask
    task automatic serve(input logic [2:0] op0, input logic [18:0] a0, input logic [7:0] d0,
                         input logic [2:0] op1, input logic [18:0] a1, input logic [7:0] d1, input int l);
        logic [2:0]  op[2] = '{op0, op1};
        logic [18:0] a[2]  = '{a0, a1};
        logic [7:0]  d[2]  = '{d0, d1};
        int          order[$], start[2], n;
        strobe_t     es[$];
        rdy_t        er[$];
        logic        p0 = |op0[1:0], p1 = |op1[1:0];
        if (p0 && p1) order = {last ? 0 : 1, last ? 1 : 0};
        else order = {p1 ? 1 : 0};
        @(negedge Clk);
        sq.delete(); rq.delete(); lat = l;
        drive(0, op0, a0, d0);
        drive(1, op1, a1, d1);
        start[order[0]] = cyc;
        foreach (order[k]) begin
            n = 0;
            do begin @(negedge Clk); n++; end while (!(Grant0 | Grant1) && n < 20);
            chk("grant_owner", {Grant1, Grant0}, order[k] ? 2 : 1);
            n = 0;
            do begin @(negedge Clk); n++; end while ((Grant0 | Grant1) && n < 100);
            chk("grant_released", {Grant1, Grant0}, 0);
            drive(order[k], 3'b000, 0, 0);
            if (k + 1 < order.size()) start[order[k+1]] = cyc;
        end
        repeat (3) @(negedge Clk);
        foreach (order[k]) begin
            int          w = order[k], sc = start[w] + 1, beats;
            logic        rd = op[w][0];
            logic [18:0] ad;
            beats = (rd && op[w][2]) ? 4 : 1;
            for (int b = 0; b < beats; b++) begin
                ad = (a[w] & ~19'h3) | ((a[w] + 19'(b)) & 19'h3);
                es.push_back('{sc, rd, ad, d[w]});
                if (l == 0) begin
                    er.push_back('{sc + 9, 2 * w + (rd ? 0 : 1), 8'h00, 1'b1});
                    break;
                end
                er.push_back('{sc + l + 1, 2 * w + (rd ? 0 : 1), mem_f(ad), 1'b0});
                sc = sc + l + 1;
            end
            last = w;
        end
        chk("n_strobes", sq.size(), es.size());
        chk("n_readies", rq.size(), er.size());
        for (int i = 0; i < sq.size() && i < es.size(); i++) begin
            chk("strobe_cycle", sq[i].cyc, es[i].cyc);
            chk("strobe_is_read", sq[i].rd, es[i].rd);
            chk("strobe_addr", sq[i].addr, es[i].addr);
            if (!es[i].rd) chk("strobe_wdata", sq[i].wd, es[i].wd);
        end
        for (int i = 0; i < rq.size() && i < er.size(); i++) begin
            chk("ready_cycle", rq[i].cyc, er[i].cyc);
            chk("ready_who", rq[i].who, er[i].who);
            chk("ready_timeout", rq[i].tmo, er[i].tmo);
            if (er[i].who % 2 == 0 || er[i].tmo) chk("ready_rd_data", rq[i].data, er[i].data);
        end
    endtask
    task automatic do_reset();
        @(negedge Clk);
        Reset_n = 0;
        repeat (2) @(negedge Clk);
        Reset_n = 1;
        last = 1;
    endtask
    initial begin
        int n, n0s, n0r;
        repeat (3) @(negedge Clk);
        chk("reset_outputs", {Grant0, Grant1, rv, Rd_Data, Mem_Read, Mem_Write, Mem_Address, Mem_WData, Timeout_Error}, 0);
        Reset_n = 1;
        serve(3'b001, 19'h00105, 8'h00, 3'b000, 0, 0, 3);
        chk("single_read_data", rq.size() > 0 ? rq[0].data : 8'hxx, 8'hA5);
        serve(3'b101, 19'h00106, 8'h00, 3'b000, 0, 0, 2);
        serve(3'b001, 19'h00333, 8'h00, 3'b000, 0, 0, 8);
        do_reset();
        serve(3'b001, 19'h00010, 8'h00, 3'b010, 19'h00222, 8'h3C, 1);
        serve(3'b001, 19'h00011, 8'h00, 3'b010, 19'h00223, 8'hC3, 2);
        serve(3'b000, 0, 0, 3'b101, 19'h00441, 8'h00, 0);
        serve(3'b000, 0, 0, 3'b011, 19'h00555, 8'h77, 2);
        serve(3'b110, 19'h00702, 8'h9E, 3'b000, 0, 0, 1);
        @(negedge Clk);
        sq.delete(); rq.delete(); lat = 2;
        Req0_Read = 1; Req0_Burst = 1; Req0_Address = 19'h00106;
        n = 0;
        while (rq.size() < 2 && n < 60) begin @(negedge Clk); #1; n++; end
        chk("rst_two_beats", rq.size(), 2);
        Reset_n = 0;
        #1;
        chk("rst_outputs_zero", {Grant0, Grant1, rv, Rd_Data, Mem_Read, Mem_Write, Mem_Address, Mem_WData, Timeout_Error}, 0);
        Req0_Read = 0; Req0_Burst = 0;
        n0s = sq.size(); n0r = rq.size();
        repeat (4) @(negedge Clk);
        Reset_n = 1;
        last = 1;
        repeat (3) @(negedge Clk);
        chk("rst_no_strobe", sq.size(), n0s);
        chk("rst_no_ready", rq.size(), n0r);
        serve(3'b001, 19'h00105, 8'h00, 3'b001, 19'h00200, 8'h00, 3);
        for (int t = 0; t < 40; t++) begin
            logic [2:0] o0 = op_of($urandom_range(0, 5)), o1 = op_of($urandom_range(0, 5));
            if (o0 == 0 && o1 == 0) o0 = 3'b001;
            serve(o0, 19'($urandom), 8'($urandom), o1, 19'($urandom), 8'($urandom),
                  ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5)));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
